// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// The datapath (master) drives the hazard sources and clear request. The hazard
// controller (slave) returns the enables, flushes and performance counters.
interface hazard_ctrl_if;
  // Hazard sources
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRt;
  logic [4:0]  IF_ID_RegisterRs;
  logic [4:0]  IF_ID_RegisterRt;
  logic        IF_ID_uses_rt;
  logic        branch_taken;
  logic        jump;
  logic        clr_counts;

  // Controller responses
  logic        PC_write;
  logic        IF_ID_write;
  logic        ID_Hazard_lwstall;
  logic        ID_Hazard_Branch;
  logic        IF_Flush;
  logic        EX_Flush;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
           IF_ID_uses_rt, branch_taken, jump, clr_counts,
    input  PC_write, IF_ID_write, ID_Hazard_lwstall, ID_Hazard_Branch, IF_Flush,
           EX_Flush, stall_count, flush_count
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
           IF_ID_uses_rt, branch_taken, jump, clr_counts,
    output PC_write, IF_ID_write, ID_Hazard_lwstall, ID_Hazard_Branch, IF_Flush,
           EX_Flush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: one-bubble load-use stall, multi-cycle redirect
// flush after a taken branch or jump, and saturating stall/flush counters.
// Hazard outputs are combinational so they act in the cycle the hazard is seen.
// FLUSH_CYCLES must lie in 1..15 (it is loaded into a 4-bit counter).
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  localparam logic [3:0] FlushLoad  = 4'(FLUSH_CYCLES - 1);
  localparam bit         MultiFlush = (FLUSH_CYCLES > 1);

  state_e      state_d, state_q;
  logic [3:0]  fcnt_d, fcnt_q;
  logic [15:0] stall_count_d, stall_count_q;
  logic [15:0] flush_count_d, flush_count_q;

  logic new_redirect;
  logic redirect;
  logic lw_hit;
  logic lwstall;

  // Hazard detection and combinational control outputs
  always_comb begin
    new_redirect = hz.branch_taken | hz.jump;
    redirect     = new_redirect | (state_q == StFlush);
    lw_hit       = hz.ID_EX_MemRead & (hz.ID_EX_RegisterRt != 5'd0) &
                   ((hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRs) |
                    (hz.IF_ID_uses_rt & (hz.ID_EX_RegisterRt == hz.IF_ID_RegisterRt)));
    // A redirect squashes the dependent instruction, so it never stalls.
    lwstall      = lw_hit & (state_q == StRun) & ~redirect;
  end

  assign hz.ID_Hazard_lwstall = lwstall;
  assign hz.PC_write          = ~lwstall;
  assign hz.IF_ID_write       = ~lwstall;
  assign hz.ID_Hazard_Branch  = redirect;
  assign hz.IF_Flush          = redirect;
  assign hz.EX_Flush          = redirect;
  assign hz.stall_count       = stall_count_q;
  assign hz.flush_count       = flush_count_q;

  // Next-state logic. The flush counter holds the number of FLUSH-state cycles
  // still to come; the redirect cycle itself is the first flush cycle, so a
  // load of FLUSH_CYCLES-1 gives FLUSH_CYCLES flush cycles in total.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (new_redirect) begin
      fcnt_d  = FlushLoad;
      state_d = MultiFlush ? StFlush : StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (lwstall) state_d = StStall;
        end
        StStall: begin
          state_d = StRun;
        end
        StFlush: begin
          // Leave on the cycle the counter runs out; flush stays asserted through it.
          if (fcnt_q <= 4'd1) begin
            fcnt_d  = 4'd0;
            state_d = StRun;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
        default: begin
          state_d = StRun;
          fcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (hz.clr_counts) begin
      stall_count_d = 16'd0;
      flush_count_d = 16'd0;
    end else begin
      if (lwstall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
      if (redirect && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      fcnt_q        <= 4'd0;
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances (FLUSH_CYCLES = 1 and 3)
// share one stimulus stream; each cycle's expected outputs for the instance of
// interest are queued, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mr, ur, br, jmp, clr;
  logic [4:0] exrt, rs, rt;

  hazard_ctrl_if if1 ();
  hazard_ctrl_if if3 ();

  assign if1.ID_EX_MemRead = mr;    assign if3.ID_EX_MemRead = mr;
  assign if1.ID_EX_RegisterRt = exrt; assign if3.ID_EX_RegisterRt = exrt;
  assign if1.IF_ID_RegisterRs = rs; assign if3.IF_ID_RegisterRs = rs;
  assign if1.IF_ID_RegisterRt = rt; assign if3.IF_ID_RegisterRt = rt;
  assign if1.IF_ID_uses_rt = ur;    assign if3.IF_ID_uses_rt = ur;
  assign if1.branch_taken = br;     assign if3.branch_taken = br;
  assign if1.jump = jmp;            assign if3.jump = jmp;
  assign if1.clr_counts = clr;      assign if3.clr_counts = clr;

  hazard_ctrl #(.FLUSH_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .hz(if1));
  hazard_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .hz(if3));

  typedef struct {
    int          sel;
    string       name;
    logic        pcw;
    logic        lws;
    logic        fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare every queued expectation against the selected instance
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [37:0] act, req;
      e = sb.pop_front();
      if (e.sel == 3)
        act = {if3.PC_write, if3.IF_ID_write, if3.ID_Hazard_lwstall, if3.ID_Hazard_Branch,
               if3.IF_Flush, if3.EX_Flush, if3.stall_count, if3.flush_count};
      else
        act = {if1.PC_write, if1.IF_ID_write, if1.ID_Hazard_lwstall, if1.ID_Hazard_Branch,
               if1.IF_Flush, if1.EX_Flush, if1.stall_count, if1.flush_count};
      req = {e.pcw, e.pcw, e.lws, e.fl, e.fl, e.fl, e.sc, e.fc};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s (dut%0d): got pcw/ifid/lws/br/iff/exf=%b sc=%h fc=%h, want %b sc=%h fc=%h",
                 e.name, e.sel, act[37:32], act[31:16], act[15:0],
                 req[37:32], req[31:16], req[15:0]);
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge
  task automatic drive(input logic r, input logic m, input logic [4:0] x,
                       input logic [4:0] s, input logic [4:0] t, input logic u,
                       input logic b, input logic j, input logic c);
    @(posedge clk);
    #1;
    rst = r; mr = m; exrt = x; rs = s; rt = t; ur = u; br = b; jmp = j; clr = c;
  endtask

  task automatic expect_out(input int sel, input string name, input logic pcw,
                            input logic lws, input logic fl, input logic [15:0] sc,
                            input logic [15:0] fc);
    exp_t e;
    e.sel = sel; e.name = name; e.pcw = pcw; e.lws = lws; e.fl = fl; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic idle(input logic r);
    drive(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mr = 0; exrt = 0; rs = 0; rt = 0; ur = 0; br = 0; jmp = 0; clr = 0;

    // Reset values with all inputs low
    idle(1'b1);
    expect_out(1, "reset_outputs", 1, 0, 0, 16'd0, 16'd0);
    expect_out(3, "reset_outputs", 1, 0, 0, 16'd0, 16'd0);

    // Load-use on rs, inputs held two cycles: exactly one bubble
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    expect_out(1, "lw_rs_cycle1", 0, 1, 0, 16'd0, 16'd0);
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    expect_out(1, "lw_rs_cycle2", 1, 0, 0, 16'd1, 16'd0);
    idle(0);
    expect_out(1, "lw_rs_count", 1, 0, 0, 16'd1, 16'd0);

    // $0 never stalls; rt only matters when the ID instruction reads it
    drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    expect_out(1, "reg0_no_stall", 1, 0, 0, 16'd1, 16'd0);
    drive(0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0);
    expect_out(1, "rt_unused_no_stall", 1, 0, 0, 16'd1, 16'd0);
    drive(0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0);
    expect_out(1, "rt_used_stall", 0, 1, 0, 16'd1, 16'd0);
    idle(0);
    expect_out(1, "rt_used_bubble_done", 1, 0, 0, 16'd2, 16'd0);

    // Redirect beats load-use in the same cycle
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0);
    expect_out(1, "lw_and_branch", 1, 0, 1, 16'd2, 16'd0);
    idle(0);
    expect_out(1, "branch_1cyc_done", 1, 0, 0, 16'd2, 16'd1);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    expect_out(1, "jump_flush", 1, 0, 1, 16'd2, 16'd1);
    idle(0);
    expect_out(1, "jump_done", 1, 0, 0, 16'd2, 16'd2);

    // Saturation: preload stall counter to FFFE, then three stalls
    @(negedge clk);
    #1 force u_dut1.stall_count_q = 16'hFFFE;
    #1 release u_dut1.stall_count_q;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0);
      expect_out(1, "sat_stall", 0, 1, 0, (i == 0) ? 16'hFFFE : 16'hFFFF, 16'd2);
      idle(0);
      expect_out(1, "sat_hold", 1, 0, 0, 16'hFFFF, 16'd2);
    end
    drive(0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 1);
    expect_out(1, "clr_with_stall", 0, 1, 0, 16'hFFFF, 16'd2);
    idle(0);
    expect_out(1, "clr_result", 1, 0, 0, 16'd0, 16'd0);

    // FLUSH_CYCLES=3: single pulse gives three flush cycles
    idle(1);
    expect_out(3, "reset3", 1, 0, 0, 16'd0, 16'd0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    expect_out(3, "f3_c1", 1, 0, 1, 16'd0, 16'd0);
    idle(0);
    expect_out(3, "f3_c2", 1, 0, 1, 16'd0, 16'd1);
    idle(0);
    expect_out(3, "f3_c3", 1, 0, 1, 16'd0, 16'd2);
    idle(0);
    expect_out(3, "f3_end", 1, 0, 0, 16'd0, 16'd3);

    // Second pulse in cycle 2 stretches the window to four cycles
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    expect_out(3, "f3x_c1", 1, 0, 1, 16'd0, 16'd3);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    expect_out(3, "f3x_c2", 1, 0, 1, 16'd0, 16'd4);
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    expect_out(3, "f3x_c3_lw_masked", 1, 0, 1, 16'd0, 16'd5);
    idle(0);
    expect_out(3, "f3x_c4", 1, 0, 1, 16'd0, 16'd6);
    idle(0);
    expect_out(3, "f3x_end", 1, 0, 0, 16'd0, 16'd7);

    // Reset during cycle 2 of a flush aborts it immediately
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    expect_out(3, "rstf_c1", 1, 0, 1, 16'd0, 16'd7);
    idle(1);
    expect_out(3, "rstf_reset", 1, 0, 0, 16'd0, 16'd0);
    drive(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    expect_out(3, "rstf_run_after", 0, 1, 0, 16'd0, 16'd0);
    idle(0);
    expect_out(3, "rstf_stall_count", 1, 0, 0, 16'd1, 16'd0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
